// File: rtl/fsm_trace_pkg.sv
// Shared widths and entry layout for the FSM trace buffer.
package fsm_trace_pkg;

  localparam int unsigned StateWidth = 4;
  localparam int unsigned DwellWidth = 8;
  localparam int unsigned Depth      = 8;
  localparam int unsigned DropWidth  = 8;

  typedef struct packed {
    logic [StateWidth-1:0] from_state;
    logic [StateWidth-1:0] to_state;
    logic [DwellWidth-1:0] dwell;
  } fsm_trace_entry_t;

endpackage

// File: rtl/fsm_trace_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full and not popping is ignored.
module fsm_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign level   = count_q;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push & (~full | do_pop);
  // Head data reads as zero while empty so idle outputs stay clean.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fsm_trace_buffer.sv
// Observes an FSM state bus and logs {from, to, dwell} per transition into a FWFT FIFO;
// entries arriving while full are dropped and counted, never stalling the observed FSM.
module fsm_trace_buffer
  import fsm_trace_pkg::*;
#(
  parameter int unsigned STATE_WIDTH = StateWidth,
  parameter int unsigned DWELL_WIDTH = DwellWidth,
  parameter int unsigned DEPTH       = Depth
) (
  input  logic                     clock_port,
  input  logic                     reset_port,
  input  logic                     enable,
  input  logic [STATE_WIDTH-1:0]   state,
  output logic                     entry_valid,
  input  logic                     entry_ready,
  output logic [STATE_WIDTH-1:0]   entry_from,
  output logic [STATE_WIDTH-1:0]   entry_to,
  output logic [DWELL_WIDTH-1:0]   entry_dwell,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [DropWidth-1:0]     drop_count,
  input  logic                     clear_overflow
);

  localparam int unsigned EntryWidth = 2 * STATE_WIDTH + DWELL_WIDTH;

  logic                   primed_q;
  logic [STATE_WIDTH-1:0] last_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic                   overflow_q;
  logic [DropWidth-1:0]   drop_q;

  logic                   changed, push, pop, full, empty, drop;
  logic [EntryWidth-1:0]  head;

  assign changed = (state != last_q);
  assign push    = ~reset_port & enable & primed_q & changed;
  assign pop     = ~empty & entry_ready;
  assign drop    = push & full & ~pop;

  always_ff @(posedge clock_port) begin
    if (reset_port) begin
      primed_q <= 1'b0;
      last_q   <= '0;
      dwell_q  <= '0;
    end else if (enable) begin
      if (!primed_q || changed) begin
        primed_q <= 1'b1;
        last_q   <= state;
        dwell_q  <= DWELL_WIDTH'(1);
      end else if (dwell_q != '1) begin
        dwell_q  <= dwell_q + DWELL_WIDTH'(1);
      end
    end
  end

  // A drop coinciding with a clear restarts the count at one rather than zero.
  always_ff @(posedge clock_port) begin
    if (reset_port) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clear_overflow)   drop_q <= DropWidth'(1);
      else if (drop_q != '1) drop_q <= drop_q + DropWidth'(1);
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end
  end

  fsm_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryWidth)
  ) u_fifo (
    .clk   (clock_port),
    .rst   (reset_port),
    .push  (push),
    .pop   (pop),
    .wdata ({last_q, state, dwell_q}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fill_level)
  );

  assign entry_valid = ~empty;
  assign entry_from  = head[EntryWidth-1 -: STATE_WIDTH];
  assign entry_to    = head[DWELL_WIDTH +: STATE_WIDTH];
  assign entry_dwell = head[DWELL_WIDTH-1:0];
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_fsm_trace_buffer.sv
// Directed bench for fsm_trace_buffer with a queue-based reference model checked every cycle.
module tb_fsm_trace_buffer;
  import fsm_trace_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, rdy, clr;
  logic [3:0] st;
  logic       entry_valid, overflow;
  logic [3:0] entry_from, entry_to;
  logic [7:0] entry_dwell, drop_count;
  logic [3:0] fill_level;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  fsm_trace_entry_t mq[$];
  logic [3:0]       m_last;
  int               m_dwell, m_drops;
  bit               m_primed, m_ovf;

  always #5 clk = ~clk;

  fsm_trace_buffer dut (
    .clock_port     (clk),
    .reset_port     (rst),
    .enable         (en),
    .state          (st),
    .entry_valid    (entry_valid),
    .entry_ready    (rdy),
    .entry_from     (entry_from),
    .entry_to       (entry_to),
    .entry_dwell    (entry_dwell),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clear_overflow (clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input int f, input int t, input int d);
    check({name, ".valid"}, 32'(entry_valid), 1);
    check({name, ".from"},  32'(entry_from),  f);
    check({name, ".to"},    32'(entry_to),    t);
    check({name, ".dwell"}, 32'(entry_dwell), d);
  endtask

  // Reference behaviour: one call per clock edge, using the inputs held across that edge.
  task automatic model_step();
    bit do_push = 1'b0;
    bit do_pop;
    bit drop = 1'b0;
    fsm_trace_entry_t e = '0;
    if (rst) begin
      mq.delete();
      m_last = '0; m_dwell = 0; m_primed = 1'b0; m_ovf = 1'b0; m_drops = 0;
      return;
    end
    do_pop = (mq.size() > 0) && rdy;
    if (en) begin
      if (!m_primed) begin
        m_primed = 1'b1; m_last = st; m_dwell = 1;
      end else if (st != m_last) begin
        do_push = 1'b1;
        e.from_state = m_last; e.to_state = st; e.dwell = 8'(m_dwell);
        m_last = st; m_dwell = 1;
      end else if (m_dwell < 255) begin
        m_dwell++;
      end
    end
    if (do_push && mq.size() == 8 && !do_pop) drop = 1'b1;
    if (do_pop) void'(mq.pop_front());
    if (do_push && !drop) mq.push_back(e);
    if (drop) begin
      m_ovf = 1'b1;
      m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
    end else if (clr) begin
      m_ovf = 1'b0; m_drops = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    fsm_trace_entry_t h;
    if (check_en) begin
      h = (mq.size() > 0) ? mq[0] : '0;
      check("cmp.valid", 32'(entry_valid), 32'(mq.size() != 0));
      check("cmp.fill",  32'(fill_level),  32'(mq.size()));
      check("cmp.from",  32'(entry_from),  32'(h.from_state));
      check("cmp.to",    32'(entry_to),    32'(h.to_state));
      check("cmp.dwell", 32'(entry_dwell), 32'(h.dwell));
      check("cmp.ovf",   32'(overflow),    32'(m_ovf));
      check("cmp.drops", 32'(drop_count),  32'(m_drops));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; rdy = 1'b0; clr = 1'b0; st = 4'h0;
    tick(); tick();
    check_en = 1'b1;
    check("reset.valid", 32'(entry_valid), 0);
    check("reset.fill",  32'(fill_level),  0);
    check("reset.ovf",   32'(overflow),    0);
    check("reset.drops", 32'(drop_count),  0);

    // Basic transition with one-cycle latency
    rst = 1'b0; en = 1'b1; rdy = 1'b1; st = 4'hb;
    repeat (5) tick();
    check("basic.pre_valid", 32'(entry_valid), 0);
    st = 4'hc;
    tick();
    check_head("basic", 'hb, 'hc, 5);
    tick();
    check("basic.popped", 32'(entry_valid), 0);

    // Dwell saturation
    st = 4'h3;
    for (int i = 0; i < 300; i++) tick();
    st = 4'h4;
    tick();
    check_head("sat", 3, 4, 255);
    tick();

    // Overflow: ten transitions into an eight-deep FIFO
    rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      st = (i % 2 == 0) ? 4'h5 : 4'h6;
      tick();
    end
    check("ovf.fill",  32'(fill_level), 8);
    check("ovf.flag",  32'(overflow),   1);
    check("ovf.drops", 32'(drop_count), 2);
    check_head("ovf.head", 4, 5, 2);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr.flag",  32'(overflow),   0);
    check("clr.drops", 32'(drop_count), 0);

    // Full with simultaneous pop and push
    rdy = 1'b1; st = 4'h7;
    tick();
    check("fullpp.fill",  32'(fill_level), 8);
    check("fullpp.drops", 32'(drop_count), 0);
    check_head("fullpp.head", 5, 6, 1);
    repeat (7) tick();
    check("fullpp.fill1", 32'(fill_level), 1);
    check_head("fullpp.tail", 6, 7, 2);
    tick();

    // Enable gap
    st = 4'h1;
    repeat (3) tick();
    en = 1'b0; st = 4'h2;
    repeat (4) tick();
    check("gap.valid", 32'(entry_valid), 0);
    en = 1'b1;
    tick();
    check_head("gap.entry", 1, 2, 3);
    tick();
    st = 4'h3;
    tick();
    check_head("gap.restart", 2, 3, 2);
    tick();

    // Reset mid-operation
    rdy = 1'b0;
    st = 4'h4; tick();
    st = 4'h5; tick();
    st = 4'h6; tick();
    check("rstmid.fill", 32'(fill_level), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rstmid.valid", 32'(entry_valid), 0);
    check("rstmid.fill0", 32'(fill_level),  0);
    check("rstmid.ovf",   32'(overflow),    0);
    st = 4'h9; tick();
    check("reprime.valid", 32'(entry_valid), 0);
    st = 4'ha; tick();
    check_head("reprime.entry", 9, 'ha, 1);
    tick();

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
